bubble_page_buffer_ctrl: RTL and testbench



---
 rtl/bubble_page_buffer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bubble_page_buffer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_page_buffer_ctrl.sv
// Ping-pong controller for two external 1024x1 page RAM banks: a serial loader fills one bank
// while the bubble streamer drains the other. Optional macro PGBUF_STATS_EN adds UNDERRUN_CNT.
module bubble_page_buffer_ctrl #(
    parameter int PAGE_LEN = 1024
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       FLUSH,
    output logic       LD_REQ,
    input  logic       LD_VALID,
    input  logic       LD_BIT,
    output logic       LD_PAGE_DONE,
    input  logic       RD_TICK,
    output logic       RD_VALID,
    output logic       RD_BIT,
    output logic       RD_PAGE_DONE,
    output logic       UNDERRUN,
    output logic       PAGE_RDY,
    output logic [9:0] WRADDR,
    output logic [9:0] RDADDR,
    output logic       DIN,
    output logic       nWE,
    output logic       nWRCLKEN0,
    output logic       nWRCLKEN1,
    output logic       nRDCLKEN0,
    output logic       nRDCLKEN1,
    input  logic       DOUT0,
    input  logic       DOUT1
`ifdef PGBUF_STATS_EN
    ,
    output logic [7:0] UNDERRUN_CNT
`endif
);

    localparam logic [9:0] LAST_ADDR = 10'(PAGE_LEN - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    logic       wsel_reg;
    logic       rsel_reg;
    logic [9:0] wptr_reg;
    logic [9:0] rptr_reg;
    logic       ld_page_done_reg;
    logic       rd_valid_reg;
    logic       rd_bit_reg;
    logic       rd_page_done_reg;
    logic       underrun_reg;

    logic       clear;
    logic       wr_accept;
    logic       rd_readable;
    logic       rd_access;
    logic       wr_last;
    logic       rd_last;
    logic [1:0] bank_is_filling;
    logic [1:0] bank_is_readable;
    logic [1:0] wr_clken_n;
    logic [1:0] rd_clken_n;
    logic [1:0] dout_vec;

    assign clear       = RST | FLUSH;
    assign dout_vec    = {DOUT1, DOUT0};
    assign LD_REQ      = bank_is_filling[wsel_reg];
    assign rd_readable = bank_is_readable[rsel_reg];
    // FLUSH/RST suppress all RAM traffic in the cycle they are asserted.
    assign wr_accept   = LD_REQ & LD_VALID & ~clear;
    assign rd_access   = RD_TICK & rd_readable & ~clear;
    assign wr_last     = (wptr_reg == LAST_ADDR);
    assign rd_last     = (rptr_reg == LAST_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            bank_state_t state_reg;
            logic        wr_sel;
            logic        rd_sel;

            assign wr_sel               = (wsel_reg == 1'(gi));
            assign rd_sel               = (rsel_reg == 1'(gi));
            assign bank_is_filling[gi]  = (state_reg == BANK_FILLING);
            assign bank_is_readable[gi] = (state_reg == BANK_FULL) || (state_reg == BANK_DRAINING);
            assign wr_clken_n[gi]       = ~(wr_accept & wr_sel);
            assign rd_clken_n[gi]       = ~(rd_access & rd_sel);

            always_ff @(posedge MCLK) begin
                if (clear) begin
                    state_reg <= BANK_EMPTY;
                end else begin
                    case (state_reg)
                        BANK_EMPTY: begin
                            if (wr_sel) state_reg <= BANK_FILLING;
                        end
                        BANK_FILLING: begin
                            if (wr_accept && wr_sel && wr_last) state_reg <= BANK_FULL;
                        end
                        BANK_FULL, BANK_DRAINING: begin
                            if (rd_access && rd_sel)
                                state_reg <= rd_last ? BANK_EMPTY : BANK_DRAINING;
                        end
                        default: state_reg <= BANK_EMPTY;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge MCLK) begin
        if (clear) begin
            wsel_reg         <= 1'b0;
            rsel_reg         <= 1'b0;
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            ld_page_done_reg <= 1'b0;
            rd_valid_reg     <= 1'b0;
            rd_bit_reg       <= 1'b0;
            rd_page_done_reg <= 1'b0;
            underrun_reg     <= 1'b0;
        end else begin
            ld_page_done_reg <= wr_accept & wr_last;
            rd_valid_reg     <= rd_access;
            rd_page_done_reg <= rd_access & rd_last;
            underrun_reg     <= RD_TICK & ~rd_readable;
            if (wr_accept) begin
                if (wr_last) begin
                    wptr_reg <= '0;
                    wsel_reg <= ~wsel_reg;
                end else begin
                    wptr_reg <= wptr_reg + 10'd1;
                end
            end
            // The bank captured on the falling edge of this cycle, so DOUT is stable here.
            if (rd_access) begin
                rd_bit_reg <= dout_vec[rsel_reg];
                if (rd_last) begin
                    rptr_reg <= '0;
                    rsel_reg <= ~rsel_reg;
                end else begin
                    rptr_reg <= rptr_reg + 10'd1;
                end
            end
        end
    end

`ifdef PGBUF_STATS_EN
    logic [7:0] underrun_cnt_reg;

    always_ff @(posedge MCLK) begin
        if (clear) begin
            underrun_cnt_reg <= '0;
        end else if (underrun_reg && (underrun_cnt_reg != 8'hFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
        end
    end

    assign UNDERRUN_CNT = underrun_cnt_reg;
`endif

    assign LD_PAGE_DONE = ld_page_done_reg;
    assign RD_VALID     = rd_valid_reg;
    assign RD_BIT       = rd_bit_reg;
    assign RD_PAGE_DONE = rd_page_done_reg;
    assign UNDERRUN     = underrun_reg;
    assign PAGE_RDY     = |bank_is_readable;
    assign WRADDR       = wptr_reg;
    assign RDADDR       = rptr_reg;
    assign DIN          = wr_accept & LD_BIT;
    assign nWE          = ~wr_accept;
    assign nWRCLKEN0    = wr_clken_n[0];
    assign nWRCLKEN1    = wr_clken_n[1];
    assign nRDCLKEN0    = rd_clken_n[0];
    assign nRDCLKEN1    = rd_clken_n[1];

endmodule

// File: tb/tb_bubble_page_buffer_ctrl.sv
// Bench for bubble_page_buffer_ctrl: behavioural RAM banks plus a page-queue reference model,
// driven by directed phases and randomized loader/streamer traffic.
module tb_bubble_page_buffer_ctrl;

    localparam int PL = 16;

    typedef logic [PL-1:0] page_t;

    logic       MCLK = 1'b0;
    logic       RST, FLUSH, LD_VALID, LD_BIT, RD_TICK;
    logic       LD_REQ, LD_PAGE_DONE, RD_VALID, RD_BIT, RD_PAGE_DONE, UNDERRUN, PAGE_RDY;
    logic [9:0] WRADDR, RDADDR;
    logic       DIN, nWE, nWRCLKEN0, nWRCLKEN1, nRDCLKEN0, nRDCLKEN1;
    logic       DOUT0 = 1'b0;
    logic       DOUT1 = 1'b0;
`ifdef PGBUF_STATS_EN
    logic [7:0] UNDERRUN_CNT;
`endif

    bubble_page_buffer_ctrl #(.PAGE_LEN(PL)) dut (
        .MCLK(MCLK), .RST(RST), .FLUSH(FLUSH),
        .LD_REQ(LD_REQ), .LD_VALID(LD_VALID), .LD_BIT(LD_BIT), .LD_PAGE_DONE(LD_PAGE_DONE),
        .RD_TICK(RD_TICK), .RD_VALID(RD_VALID), .RD_BIT(RD_BIT), .RD_PAGE_DONE(RD_PAGE_DONE),
        .UNDERRUN(UNDERRUN), .PAGE_RDY(PAGE_RDY), .WRADDR(WRADDR), .RDADDR(RDADDR),
        .DIN(DIN), .nWE(nWE), .nWRCLKEN0(nWRCLKEN0), .nWRCLKEN1(nWRCLKEN1),
        .nRDCLKEN0(nRDCLKEN0), .nRDCLKEN1(nRDCLKEN1), .DOUT0(DOUT0), .DOUT1(DOUT1)
`ifdef PGBUF_STATS_EN
        , .UNDERRUN_CNT(UNDERRUN_CNT)
`endif
    );

    always #5 MCLK = ~MCLK;

    // External 1024x1 banks: write and read capture on the falling edge.
    logic ram0 [1024];
    logic ram1 [1024];
    always @(negedge MCLK) begin
        if (!nWE && !nWRCLKEN0) ram0[WRADDR] <= DIN;
        if (!nWE && !nWRCLKEN1) ram1[WRADDR] <= DIN;
        if (!nRDCLKEN0) DOUT0 <= ram0[RDADDR];
        if (!nRDCLKEN1) DOUT1 <= ram1[RDADDR];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: complete pages wait in a queue; the front page is the one being streamed.
    page_t pages[$];
    page_t fill_buf;
    int    fill_cnt, rd_idx, uc_exp;
    bit    filling, wbank, rbank;
    logic  e_rd_valid, e_rd_bit, e_rd_done, e_under, e_ld_done;

    task automatic model_clear();
        pages.delete();
        fill_buf = '0; fill_cnt = 0; rd_idx = 0; uc_exp = 0;
        filling = 0; wbank = 0; rbank = 0;
        e_rd_valid = 0; e_rd_bit = 0; e_rd_done = 0; e_under = 0; e_ld_done = 0;
    endtask

    task automatic model_edge(input logic ldv, input logic ldb, input logic tick);
        page_t pg;
        bit    become;
        // A free bank (fewer than two pages held) is claimed by the loader one cycle later.
        become     = !filling && (pages.size() < 2);
        e_rd_valid = 0; e_rd_done = 0; e_under = 0; e_ld_done = 0;
        if (tick) begin
            if (pages.size() > 0) begin
                pg = pages[0];
                e_rd_valid = 1;
                e_rd_bit   = pg[rd_idx];
                if (rd_idx == PL - 1) begin
                    e_rd_done = 1;
                    void'(pages.pop_front());
                    rd_idx = 0;
                    rbank  = ~rbank;
                end else begin
                    rd_idx++;
                end
            end else begin
                e_under = 1;
                if (uc_exp < 255) uc_exp++;
            end
        end
        if (filling && ldv) begin
            fill_buf[fill_cnt] = ldb;
            if (fill_cnt == PL - 1) begin
                pages.push_back(fill_buf);
                fill_cnt  = 0;
                filling   = 0;
                wbank     = ~wbank;
                e_ld_done = 1;
            end else begin
                fill_cnt++;
            end
        end else if (become) begin
            filling = 1;
        end
    endtask

    // One clock cycle: drive, check same-cycle RAM controls, advance model, check registered outputs.
    task automatic step(input logic rst, input logic flush, input logic ldv, input logic ldb,
                        input logic tick);
        bit acc, rd;
        RST = rst; FLUSH = flush; LD_VALID = ldv; LD_BIT = ldb; RD_TICK = tick;
        #2;
        if (!rst) begin
            acc = filling && ldv && !flush;
            rd  = tick && (pages.size() > 0) && !flush;
            check_val("nwe", 32'(nWE), 32'(!acc));
            check_val("nwrclken0", 32'(nWRCLKEN0), 32'(!(acc && wbank == 0)));
            check_val("nwrclken1", 32'(nWRCLKEN1), 32'(!(acc && wbank == 1)));
            check_val("nrdclken0", 32'(nRDCLKEN0), 32'(!(rd && rbank == 0)));
            check_val("nrdclken1", 32'(nRDCLKEN1), 32'(!(rd && rbank == 1)));
            check_val("wraddr", 32'(WRADDR), 32'(fill_cnt));
            check_val("rdaddr", 32'(RDADDR), 32'(rd_idx));
            if (acc) check_val("din", 32'(DIN), 32'(ldb));
        end
        if (rst || flush) model_clear();
        else model_edge(ldv, ldb, tick);
        @(posedge MCLK);
        #1;
        check_val("ld_req", 32'(LD_REQ), 32'(filling));
        check_val("page_rdy", 32'(PAGE_RDY), 32'(pages.size() > 0));
        check_val("rd_valid", 32'(RD_VALID), 32'(e_rd_valid));
        check_val("rd_bit", 32'(RD_BIT), 32'(e_rd_bit));
        check_val("rd_page_done", 32'(RD_PAGE_DONE), 32'(e_rd_done));
        check_val("underrun", 32'(UNDERRUN), 32'(e_under));
        check_val("ld_page_done", 32'(LD_PAGE_DONE), 32'(e_ld_done));
`ifdef PGBUF_STATS_EN
        // The counter lags the UNDERRUN pulse by one cycle.
        check_val("underrun_cnt", 32'(UNDERRUN_CNT), 32'(uc_exp - ((e_under && uc_exp <= 255 && uc_exp > 0 && !(uc_exp == 255 && UNDERRUN_CNT == 8'hFF)) ? 1 : 0)));
`endif
        if (LD_PAGE_DONE) $display("page loaded   t=%0t", $time);
        if (RD_PAGE_DONE) $display("page streamed t=%0t", $time);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    page_t pat;
    page_t rd_word;

    initial begin
        RST = 1; FLUSH = 0; LD_VALID = 0; LD_BIT = 0; RD_TICK = 0;
        model_clear();
        pat = 16'hA5C3;
        rd_word = '0;
        @(posedge MCLK);
        #1;

        // Reset held for two cycles, then loader request appears after release.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("rst_nwe", 32'(nWE), 32'd1);
        check_val("rst_wraddr", 32'(WRADDR), 32'd0);
        idle(2);
        check_val("ld_req_after_rst", 32'(LD_REQ), 32'd1);

        // Fill one page with the reference pattern, LSB first.
        for (int i = 0; i < PL; i++) step(0, 0, 1, pat[i], 0);
        check_val("page_rdy_after_fill", 32'(PAGE_RDY), 32'd1);
        idle(2);

        // Drain with ticks spaced three cycles.
        for (int i = 0; i < PL; i++) begin
            step(0, 0, 0, 0, 1);
            rd_word[i] = RD_BIT;
            idle(2);
        end
        check_val("drain_word", 32'(rd_word), 32'(pat));

        // Underruns with nothing readable; 300 ticks saturate the optional counter.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1);

        // Concurrent fill of one bank while the other drains every cycle.
        step(0, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < PL; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 3 * PL; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 1);

        // Flush mid-fill at wptr=7, then mid-drain; refill restarts at address 0.
        step(0, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 0);
        check_val("wptr_before_flush", 32'(WRADDR), 32'd7);
        step(0, 1, 0, 0, 0);
        check_val("flush_page_rdy", 32'(PAGE_RDY), 32'd0);
        idle(1);
        for (int i = 0; i < PL + 4; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        check_val("flush_rdaddr", 32'(RDADDR), 32'd0);
        idle(2);

        // Randomized traffic with varying loader and streamer rates.
        for (int seg = 0; seg < 6; seg++) begin
            int pv, pt;
            pv = $urandom_range(1, 4);
            pt = $urandom_range(1, 4);
            for (int i = 0; i < 250; i++) begin
                step(0, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(1, 4) <= pv) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(1, 4) <= pt) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
